// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the async SRAM responder
package sram_pkg;

  localparam int SRAM_ADDR_W = 15;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE_PULSE
  } sram_rsp_state_t;

  // Observability counters stick at all-ones instead of wrapping
  function automatic logic [SRAM_CNT_W-1:0] sat_inc(input logic [SRAM_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_mem_array.sv
// rtl/sram_mem_array.sv - single-port synchronous RAM with registered read
module sram_mem_array
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // One shared address; the read register holds its value while rd_en is low
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - clocked chip-side emulation of an async SRAM
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     sram_addr,
  inout  wire  [DATA_W-1:0]     sram_data,
  input  logic                  sram_ce,
  input  logic                  sram_oe,
  input  logic                  sram_we,
  output logic                  bus_drive,
  output logic [SRAM_CNT_W-1:0] rd_count,
  output logic [SRAM_CNT_W-1:0] wr_count,
  output logic                  proto_err
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  sram_rsp_state_t   state;
  logic              s_ce, s_oe, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_data;
  logic              addr_chg;
  logic              mem_wr_en;
  logic              mem_rd_en;

  assign addr_chg = (s_addr != lat_addr);

  // Commit happens on the cycle the FSM leaves WRITE_PULSE; reset drops it
  assign mem_wr_en = !rst && (state == WRITE_PULSE) && (s_we || s_ce);

  // Read fires exactly when READ_WAIT hands over to READ_DRIVE, so the RAM
  // read register doubles as the held output register
  assign mem_rd_en = !rst && (state == READ_WAIT) && !s_ce && !s_oe && s_we
                     && !addr_chg && (cnt == '0);

  assign sram_data = bus_drive ? rd_data : 'z;

  sram_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .addr    (lat_addr),
    .wr_en   (mem_wr_en),
    .wr_data (wdata),
    .rd_en   (mem_rd_en),
    .rd_data (rd_data)
  );

  // Single sample stage on every pin; the FSM only ever sees these copies
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ce   <= 1'b1;
      s_oe   <= 1'b1;
      s_we   <= 1'b1;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      s_ce   <= sram_ce;
      s_oe   <= sram_oe;
      s_we   <= sram_we;
      s_addr <= sram_addr;
      s_data <= sram_data;
    end
  end

  // Access FSM: ce/oe deassert > we > address change > access counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_drive <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
      cnt       <= '0;
      lat_addr  <= '0;
      wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!s_ce && !s_we) begin
            state    <= WRITE_PULSE;
            lat_addr <= s_addr;
            wdata    <= s_data;
          end else if (!s_ce && !s_oe) begin
            state    <= READ_WAIT;
            lat_addr <= s_addr;
            cnt      <= CNT_LOAD;
          end
        end

        READ_WAIT: begin
          if (s_ce || s_oe) begin
            state <= IDLE;
          end else if (!s_we) begin
            state    <= WRITE_PULSE;
            lat_addr <= s_addr;
            wdata    <= s_data;
          end else if (addr_chg) begin
            lat_addr <= s_addr;
            cnt      <= CNT_LOAD;
          end else if (cnt == '0) begin
            state     <= READ_DRIVE;
            bus_drive <= 1'b1;
            rd_count  <= sat_inc(rd_count);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        READ_DRIVE: begin
          if (s_ce || s_oe) begin
            state     <= IDLE;
            bus_drive <= 1'b0;
          end else if (!s_we) begin
            state     <= WRITE_PULSE;
            bus_drive <= 1'b0;
            lat_addr  <= s_addr;
            wdata     <= s_data;
          end else if (addr_chg) begin
            state     <= READ_WAIT;
            bus_drive <= 1'b0;
            lat_addr  <= s_addr;
            cnt       <= CNT_LOAD;
          end
        end

        WRITE_PULSE: begin
          if (s_we || s_ce) begin
            state    <= IDLE;
            wr_count <= sat_inc(wr_count);
          end else begin
            wdata <= s_data;
            if (addr_chg) begin
              proto_err <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          bus_drive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for the async SRAM responder
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_ce, sram_oe, sram_we;
  logic        bus_drive;
  logic [15:0] rd_count, wr_count;
  logic        proto_err;

  logic        tb_drv;
  logic [15:0] tb_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic        drv_prev = 1'b0;

  assign sram_data = tb_drv ? tb_data : 'z;

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_W        (15),
    .DATA_W        (16),
    .ACCESS_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce   (sram_ce),
    .sram_oe   (sram_oe),
    .sram_we   (sram_we),
    .bus_drive (bus_drive),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Every rising edge of bus_drive must match a read the stimulus announced
  always @(negedge clk) begin
    if (bus_drive && !drv_prev) begin
      if (exp_q.size() > 0) check("rd_data", 32'(sram_data), 32'(exp_q.pop_front()));
      else check("unexp_drive", 32'(bus_drive), 32'd0);
    end
    drv_prev = bus_drive;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pins_idle();
    sram_ce = 1'b1;
    sram_oe = 1'b1;
    sram_we = 1'b1;
    tb_drv  = 1'b0;
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [15:0] data);
    sram_addr = addr;
    tb_data   = data;
    tb_drv    = 1'b1;
    sram_ce   = 1'b0;
    sram_oe   = 1'b1;
    sram_we   = 1'b0;
    step();
    step();
    sram_we = 1'b1;
    sram_ce = 1'b1;
    step();
    tb_drv = 1'b0;
    step();
  endtask

  task automatic read_start(input logic [14:0] addr);
    sram_addr = addr;
    sram_ce   = 1'b0;
    sram_oe   = 1'b0;
    sram_we   = 1'b1;
  endtask

  // Pins were just set: drive must rise exactly on the third edge after sampling
  task automatic read_lat(input logic [15:0] exp);
    step();
    step();
    step();
    check("rd_early", 32'(bus_drive), 32'd0);
    exp_q.push_back(exp);
    step();
    check("rd_drive", 32'(bus_drive), 32'd1);
  endtask

  task automatic read_end();
    sram_ce = 1'b1;
    sram_oe = 1'b1;
    step();
    check("rel_hold", 32'(bus_drive), 32'd1);
    step();
    check("rel_done", 32'(bus_drive), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    sram_addr = '0;
    tb_data   = '0;
    pins_idle();
    repeat (3) step();
    check("rst_drive", 32'(bus_drive), 32'd0);
    check("rst_rd",    32'(rd_count),  32'd0);
    check("rst_wr",    32'(wr_count),  32'd0);
    check("rst_perr",  32'(proto_err), 32'd0);
    rst = 1'b0;
    step();

    // Basic write then read with exact latency
    do_write(15'h0006, 16'h6666);
    do_write(15'h0005, 16'h1234);
    check("wr_count_a", 32'(wr_count), 32'd2);
    read_start(15'h0005);
    read_lat(16'h1234);
    check("rd_count_a", 32'(rd_count), 32'd1);

    // Address change while driving: release next edge, restart access time
    sram_addr = 15'h0006;
    step();
    check("chg_hold", 32'(bus_drive), 32'd1);
    step();
    check("chg_release", 32'(bus_drive), 32'd0);
    step();
    check("chg_early", 32'(bus_drive), 32'd0);
    exp_q.push_back(16'h6666);
    step();
    check("chg_drive", 32'(bus_drive), 32'd1);
    check("rd_count_b", 32'(rd_count), 32'd2);
    read_end();

    // oe and we low together: write wins, no drive, no read counted
    sram_addr = 15'h0010;
    tb_data   = 16'hBEEF;
    tb_drv    = 1'b1;
    sram_ce   = 1'b0;
    sram_oe   = 1'b0;
    sram_we   = 1'b0;
    repeat (2) begin
      step();
      check("ow_nodrive", 32'(bus_drive), 32'd0);
    end
    pins_idle();
    tb_drv = 1'b1;
    step();
    tb_drv = 1'b0;
    step();
    check("ow_wr", 32'(wr_count), 32'd3);
    check("ow_rd", 32'(rd_count), 32'd2);
    step();
    read_start(15'h0010);
    read_lat(16'hBEEF);
    check("rd_count_c", 32'(rd_count), 32'd3);
    read_end();

    // Address moves mid write pulse: sticky error, commit to original address
    do_write(15'h0021, 16'h1111);
    check("perr_clean", 32'(proto_err), 32'd0);
    sram_addr = 15'h0020;
    tb_data   = 16'h7777;
    tb_drv    = 1'b1;
    sram_ce   = 1'b0;
    sram_oe   = 1'b1;
    sram_we   = 1'b0;
    step();
    step();
    sram_addr = 15'h0021;
    step();
    step();
    sram_we = 1'b1;
    sram_ce = 1'b1;
    step();
    tb_drv = 1'b0;
    step();
    check("perr_set", 32'(proto_err), 32'd1);
    check("wr_count_d", 32'(wr_count), 32'd5);
    read_start(15'h0020);
    read_lat(16'h7777);
    read_end();
    read_start(15'h0021);
    read_lat(16'h1111);
    read_end();
    check("rd_count_d", 32'(rd_count), 32'd5);
    check("perr_sticky", 32'(proto_err), 32'd1);

    // Reset in READ_WAIT: outputs clear, memory survives
    do_write(15'h0001, 16'hA5A5);
    read_start(15'h0001);
    step();
    step();
    rst = 1'b1;
    pins_idle();
    step();
    check("mrst_drive", 32'(bus_drive), 32'd0);
    check("mrst_rd",    32'(rd_count),  32'd0);
    check("mrst_wr",    32'(wr_count),  32'd0);
    check("mrst_perr",  32'(proto_err), 32'd0);
    rst = 1'b0;
    step();
    step();
    check("mrst_nodrive", 32'(bus_drive), 32'd0);
    read_start(15'h0001);
    read_lat(16'hA5A5);
    check("rd_count_e", 32'(rd_count), 32'd1);
    read_end();

    // ce drops one cycle into READ_WAIT: access aborted
    read_start(15'h0005);
    step();
    step();
    pins_idle();
    repeat (4) begin
      step();
      check("abort_nodrive", 32'(bus_drive), 32'd0);
    end
    check("abort_rd", 32'(rd_count), 32'd1);

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
